// File: rtl/udp_rx_payload_reader.sv
// Payload RAM read sequencer: on each packet-complete pulse it walks the
// payload RAM from address 0 and streams the bytes out on a valid/ready byte
// interface with first/last markers, counting packets it has to drop.
module udp_rx_payload_reader #(
  parameter int ADDR_W  = 11,
  parameter int HDR_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_valid,
  input  logic [15:0]       rec_len,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_first,
  output logic              m_last,
  output logic [15:0]       m_len,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  // Two slots absorb backpressure; the third covers the two-cycle
  // address->RAM->FIFO loop so a continuously ready sink sees no bubbles.
  localparam int          DEPTH    = 3;
  localparam logic [16:0] MAX_PLEN = 17'(2 ** ADDR_W);

  state_t            state, state_nx;
  logic [ADDR_W:0]   cnt;      // reads issued this packet
  logic [ADDR_W:0]   cnt_nx;
  logic [ADDR_W:0]   pidx;     // bytes written into the FIFO this packet
  logic              pend;     // ram_raddr carries a live read this cycle
  logic              arrive;   // ram_rdata carries a live byte this cycle
  logic [9:0]        fifo [DEPTH];
  logic [1:0]        wptr, rptr, fcnt;
  logic [2:0]        occ;
  logic [15:0]       plen;
  logic              len_ok, start, drop, issue, push, pop, done;
  logic              first_b, last_b;

  assign plen    = rec_len - 16'(HDR_LEN);
  assign len_ok  = (rec_len > 16'(HDR_LEN)) && ({1'b0, plen} <= MAX_PLEN);
  assign busy    = (state != IDLE);
  assign start   = (state == IDLE) && rec_valid && len_ok;
  assign drop    = rec_valid && !start;
  assign push    = arrive;
  assign m_valid = (fcnt != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo[rptr][7:0];
  assign m_first = m_valid && fifo[rptr][8];
  assign m_last  = m_valid && fifo[rptr][9];
  assign first_b = (pidx == '0);
  assign last_b  = (16'(pidx) == m_len - 16'd1);
  // Slots already claimed once this cycle's pop is accounted for.
  assign occ     = {1'b0, fcnt} + {2'b0, arrive} + {2'b0, pend} - {2'b0, pop};
  assign done    = !pend && !arrive && ((fcnt == 2'd0) || ((fcnt == 2'd1) && pop));

  // Next state and read-issue decision.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    cnt_nx   = cnt;
    case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: begin
        issue  = (16'(cnt) < m_len) && (occ < 3'd3);
        cnt_nx = cnt + {{ADDR_W{1'b0}}, issue};
        if (16'(cnt_nx) == m_len) state_nx = DRAIN;
      end
      DRAIN: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, read address sequencing, packet length and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_raddr <= '0;
      cnt       <= '0;
      pidx      <= '0;
      pend      <= 1'b0;
      arrive    <= 1'b0;
      m_len     <= '0;
      overrun   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state  <= state_nx;
      arrive <= pend;
      if (push) pidx <= pidx + 1'b1;
      if (start) begin
        // Address 0 goes out on the cycle right after the start pulse.
        m_len     <= plen;
        ram_raddr <= '0;
        cnt       <= {{ADDR_W{1'b0}}, 1'b1};
        pend      <= 1'b1;
        pidx      <= '0;
        overrun   <= 1'b0;
      end else begin
        pend <= issue;
        if (issue) begin
          ram_raddr <= ram_raddr + 1'b1;
          cnt       <= cnt_nx;
        end
      end
      if (rec_valid && busy) overrun <= 1'b1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Output FIFO: bytes tagged with first/last as they return from the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= {last_b, first_b, ram_rdata};
        wptr       <= (wptr == 2'(DEPTH - 1)) ? 2'd0 : wptr + 2'd1;
      end
      if (pop) rptr <= (rptr == 2'(DEPTH - 1)) ? 2'd0 : rptr + 2'd1;
      fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_udp_rx_payload_reader.sv
// Directed bench for udp_rx_payload_reader with a behavioural payload RAM.
module tb_udp_rx_payload_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rec_valid;
  logic [15:0] rec_len;
  logic [10:0] ram_raddr;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_first;
  logic        m_last;
  logic [15:0] m_len;
  logic        busy;
  logic        overrun;
  logic [15:0] drop_cnt;

  udp_rx_payload_reader #(.ADDR_W(11), .HDR_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .rec_valid(rec_valid), .rec_len(rec_len),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_first(m_first), .m_last(m_last),
    .m_len(m_len), .busy(busy), .overrun(overrun), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] ram [2048];
  logic rand_ready = 1'b0;
  logic ready_fix  = 1'b1;

  // Accepted-byte log and protocol watchers.
  logic [7:0] got_d [$];
  logic       got_f [$];
  logic       got_l [$];
  int         got_c [$];
  int         stab_err = 0;
  int         maxaddr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: data for the address of cycle t appears in cycle t+1.
  always @(posedge clk) ram_rdata <= ram[ram_raddr];

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  initial begin
    logic       hold;
    logic [7:0] pd;
    logic       pf, pl;
    hold = 1'b0; pd = 8'h00; pf = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold && !(m_valid === 1'b1 && m_data === pd && m_first === pf && m_last === pl))
          stab_err++;
        if (m_valid && m_ready) begin
          got_d.push_back(m_data);
          got_f.push_back(m_first);
          got_l.push_back(m_last);
          got_c.push_back(cyc);
        end
        hold = m_valid && !m_ready;
        pd = m_data; pf = m_first; pl = m_last;
        if (int'(ram_raddr) > maxaddr) maxaddr = int'(ram_raddr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    got_d.delete(); got_f.delete(); got_l.delete(); got_c.delete();
  endtask

  task automatic send(input logic [15:0] len, output int t);
    @(posedge clk);
    #1;
    rec_valid = 1'b1;
    rec_len   = len;
    t         = cyc;
    @(posedge clk);
    #1;
    rec_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== ram[i]) bad++;
      if (got_f[i] !== (i == 0)) bad++;
      if (got_l[i] !== (i == n - 1)) bad++;
    end
    check({tag, "_count"}, 32'(got_d.size()), 32'(n));
    check({tag, "_bytes"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int t, t2;
    rst_n = 1'b0; rec_valid = 1'b0; rec_len = 16'h0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'((i * 29) + ((i >> 8) * 7) + 5);
    ram[0] = 8'hA0; ram[1] = 8'hA1; ram[2] = 8'hA2; ram[3] = 8'hA3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_raddr",   32'(ram_raddr), 32'd0);
    check("rst_valid",   32'(m_valid),   32'd0);
    check("rst_first",   32'(m_first),   32'd0);
    check("rst_last",    32'(m_last),    32'd0);
    check("rst_data",    32'(m_data),    32'd0);
    check("rst_len",     32'(m_len),     32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    check("rst_drop",    32'(drop_cnt),  32'd0);
    rst_n = 1'b1;

    // 4-byte packet at full rate: timing, data, markers.
    clear_log();
    send(16'd12, t);
    @(negedge clk);
    check("t1_raddr0", 32'(ram_raddr), 32'd0);
    check("t1_busy",   32'(busy),      32'd1);
    check("t1_mlen",   32'(m_len),     32'd4);
    wait_idle(50);
    check_stream("t1", 4);
    check("t1_first_cyc", 32'(got_c[0]), 32'(t + 3));
    check("t1_last_cyc",  32'(got_c[3]), 32'(t + 6));
    check("t1_busy_end",  32'(busy),     32'd0);

    // Single-byte packet: first and last on the same byte.
    clear_log();
    send(16'd9, t);
    wait_idle(50);
    check_stream("t2", 1);
    check("t2_mlen", 32'(m_len), 32'd1);

    // Zero, undersized and oversized lengths are dropped.
    clear_log();
    send(16'd8, t);
    send(16'd5, t);
    send(16'd2057, t);
    repeat (6) @(negedge clk);
    check("t3_no_bytes", 32'(got_d.size()), 32'd0);
    check("t3_drop",     32'(drop_cnt),     32'd3);
    check("t3_busy",     32'(busy),         32'd0);

    // Maximum packet under random backpressure.
    clear_log();
    maxaddr = 0;
    rand_ready = 1'b1;
    send(16'd2056, t);
    wait_idle(20000);
    rand_ready = 1'b0;
    check_stream("t4", 2048);
    check("t4_maxaddr", 32'(maxaddr), 32'd2047);
    check("t4_mlen",    32'(m_len),   32'd2048);
    check("t4_stable",  32'(stab_err), 32'd0);

    // New packet while busy: ignored, counted, flagged.
    clear_log();
    send(16'd108, t);
    repeat (10) @(posedge clk);
    send(16'd20, t2);
    @(negedge clk);
    check("t5_overrun", 32'(overrun),  32'd1);
    check("t5_drop",    32'(drop_cnt), 32'd4);
    check("t5_mlen",    32'(m_len),    32'd100);
    wait_idle(400);
    check_stream("t5", 100);
    check("t5_overrun_hold", 32'(overrun), 32'd1);
    clear_log();
    send(16'd10, t);
    @(negedge clk);
    check("t5_overrun_clr", 32'(overrun), 32'd0);
    wait_idle(50);
    check_stream("t5b", 2);

    // Reset in the middle of a packet.
    clear_log();
    send(16'd108, t);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_raddr", 32'(ram_raddr), 32'd0);
    check("t6_valid", 32'(m_valid),   32'd0);
    check("t6_data",  32'(m_data),    32'd0);
    check("t6_len",   32'(m_len),     32'd0);
    check("t6_busy",  32'(busy),      32'd0);
    check("t6_drop",  32'(drop_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    send(16'd10, t);
    wait_idle(50);
    check_stream("t6", 2);
    check("t6_raddr_end", 32'(ram_raddr), 32'd1);
    check("stable_all", 32'(stab_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
